// File: rtl/hitbox_scan.sv
// Multi-target collision engine: snapshots one object and N_TARGETS targets on start, then
// tests one target per cycle through a shared squared-distance unit (circle or box per target).
module hitbox_scan #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned N_TARGETS = 4,
    parameter int unsigned COOLDOWN  = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [COORD_W-1:0]             Obj_X,
    input  logic [COORD_W-1:0]             Obj_Y,
    input  logic [COORD_W-1:0]             Coverage,
    input  logic [N_TARGETS*COORD_W-1:0]   Target_X,
    input  logic [N_TARGETS*COORD_W-1:0]   Target_Y,
    input  logic [N_TARGETS-1:0]           box_mode,
    output logic                           busy,
    output logic                           done,
    output logic [N_TARGETS-1:0]           contact,
    output logic [N_TARGETS-1:0]           hit
);

    localparam int unsigned IdxW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam int unsigned CdW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned SqW  = 2 * COORD_W + 3;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_TARGETS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

    state_e                         state_q, state_d;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic [N_TARGETS-1:0]           pend_q, pend_d;
    logic [N_TARGETS-1:0]           contact_q, contact_d;
    logic [N_TARGETS-1:0]           hit_q, hit_d;
    logic                           done_q, done_d;
    logic [COORD_W-1:0]             snap_ox_q, snap_ox_d, snap_oy_q, snap_oy_d;
    logic [COORD_W-1:0]             snap_cov_q, snap_cov_d;
    logic [N_TARGETS*COORD_W-1:0]   snap_tx_q, snap_tx_d, snap_ty_q, snap_ty_d;
    logic [N_TARGETS-1:0]           snap_box_q, snap_box_d;
    logic [CdW-1:0]                 cd_q [N_TARGETS];
    logic [CdW-1:0]                 cd_d [N_TARGETS];

    // Shared test unit for target[idx_q]
    logic [COORD_W-1:0] cur_tx, cur_ty;
    logic [COORD_W:0]   dx, dy, adx, ady;
    logic [SqW-1:0]     dist_sq, cov_sq;
    logic               circle_ok, box_ok, tgt_hit;

    always_comb begin
        cur_tx = snap_tx_q[idx_q*COORD_W +: COORD_W];
        cur_ty = snap_ty_q[idx_q*COORD_W +: COORD_W];
        // Zero-extend before subtracting so the difference is an exact signed COORD_W+1 value
        dx  = {1'b0, cur_tx} - {1'b0, snap_ox_q};
        dy  = {1'b0, cur_ty} - {1'b0, snap_oy_q};
        adx = dx[COORD_W] ? (~dx + 1'b1) : dx;
        ady = dy[COORD_W] ? (~dy + 1'b1) : dy;
        dist_sq   = SqW'(adx) * SqW'(adx) + SqW'(ady) * SqW'(ady);
        cov_sq    = SqW'(snap_cov_q) * SqW'(snap_cov_q);
        circle_ok = (dist_sq <= cov_sq);
        box_ok    = (adx <= {1'b0, snap_cov_q}) && (ady <= {1'b0, snap_cov_q});
        tgt_hit   = snap_box_q[idx_q] ? box_ok : circle_ok;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        contact_d  = contact_q;
        hit_d      = '0;
        done_d     = 1'b0;
        snap_ox_d  = snap_ox_q;
        snap_oy_d  = snap_oy_q;
        snap_cov_d = snap_cov_q;
        snap_tx_d  = snap_tx_q;
        snap_ty_d  = snap_ty_q;
        snap_box_d = snap_box_q;
        cd_d       = cd_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_ox_d  = Obj_X;
                    snap_oy_d  = Obj_Y;
                    snap_cov_d = Coverage;
                    snap_tx_d  = Target_X;
                    snap_ty_d  = Target_Y;
                    snap_box_d = box_mode;
                    idx_d      = '0;
                    pend_d     = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                pend_d[idx_q] = tgt_hit;
                idx_d         = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                contact_d = pend_q;
                done_d    = 1'b1;
                for (int i = 0; i < N_TARGETS; i++) begin
                    // Rising edges that land inside the cooldown window are dropped, not deferred
                    if (pend_q[i] && !contact_q[i] && (cd_q[i] == '0)) begin
                        hit_d[i] = 1'b1;
                        cd_d[i]  = CdW'(COOLDOWN);
                    end else if (cd_q[i] != '0) begin
                        cd_d[i] = cd_q[i] - 1'b1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pend_q     <= '0;
            contact_q  <= '0;
            hit_q      <= '0;
            done_q     <= 1'b0;
            snap_ox_q  <= '0;
            snap_oy_q  <= '0;
            snap_cov_q <= '0;
            snap_tx_q  <= '0;
            snap_ty_q  <= '0;
            snap_box_q <= '0;
            for (int i = 0; i < N_TARGETS; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            contact_q  <= contact_d;
            hit_q      <= hit_d;
            done_q     <= done_d;
            snap_ox_q  <= snap_ox_d;
            snap_oy_q  <= snap_oy_d;
            snap_cov_q <= snap_cov_d;
            snap_tx_q  <= snap_tx_d;
            snap_ty_q  <= snap_ty_d;
            snap_box_q <= snap_box_d;
            cd_q       <= cd_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign contact = contact_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_hitbox_scan.sv
// Bench for hitbox_scan: cycle-by-cycle comparison against a scan-level model, plus
// directed scans with hand-computed contact/hit literals.
module tb_hitbox_scan;

    localparam int unsigned W  = 10;
    localparam int unsigned N  = 4;
    localparam int unsigned CD = 8;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     ox = '0, oy = '0, cov = '0;
    logic [N*W-1:0]   tx = '0, ty = '0;
    logic [N-1:0]     bm = '0;
    logic             busy, done;
    logic [N-1:0]     contact, hit;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    hitbox_scan #(.COORD_W(W), .N_TARGETS(N), .COOLDOWN(CD)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .start    (start),
        .Obj_X    (ox),
        .Obj_Y    (oy),
        .Coverage (cov),
        .Target_X (tx),
        .Target_Y (ty),
        .box_mode (bm),
        .busy     (busy),
        .done     (done),
        .contact  (contact),
        .hit      (hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_contact(input int a_ox, input int a_oy, input int a_cov,
                                         input int a_tx, input int a_ty, input bit a_box);
        int dx = a_tx - a_ox;
        int dy = a_ty - a_oy;
        if (a_box) begin
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            return (dx <= a_cov) && (dy <= a_cov);
        end
        return (dx * dx + dy * dy) <= (a_cov * a_cov);
    endfunction

    function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Scan-level model: m_age is the current cycle's offset from the accepted start
    int           m_age = 0;
    int           scan_no = 0;
    int           last_hit [N];
    logic [N-1:0] m_pend = '0, m_contact = '0, e_hit = '0;
    bit           e_done = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) last_hit[i] = -1000;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", busy, (m_age >= 1 && m_age <= N + 1));
                check("done", done, e_done);
                check("contact", contact, m_contact);
                check("hit", hit, e_hit);
            end
            if (rst) begin
                m_age = 0;
                m_contact = '0;
                e_done = 1'b0;
                e_hit = '0;
                for (int i = 0; i < N; i++) last_hit[i] = -1000;
            end else begin
                bit acc;
                acc = start && !(m_age >= 1 && m_age <= N + 1);
                e_done = 1'b0;
                e_hit = '0;
                if (m_age == N + 1) begin
                    scan_no++;
                    for (int i = 0; i < N; i++) begin
                        if (m_pend[i] && !m_contact[i] && (scan_no - last_hit[i] > CD)) begin
                            e_hit[i] = 1'b1;
                            last_hit[i] = scan_no;
                        end
                    end
                    m_contact = m_pend;
                    e_done = 1'b1;
                    m_age = 0;
                end else if (m_age >= 1) begin
                    m_age++;
                end
                if (acc) begin
                    m_age = 1;
                    for (int i = 0; i < N; i++)
                        m_pend[i] = model_contact(ox, oy, cov, tx[i*W +: W], ty[i*W +: W], bm[i]);
                end
            end
        end
    end

    task automatic run_scan(input int o_x, input int o_y, input int c,
                            input logic [N*W-1:0] t_x, input logic [N*W-1:0] t_y,
                            input logic [N-1:0] b, input logic [N-1:0] exp_c,
                            input logic [N-1:0] exp_h, input string nm);
        int lat;
        @(posedge clk); #1;
        ox = W'(o_x); oy = W'(o_y); cov = W'(c); tx = t_x; ty = t_y; bm = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tx = ~t_x; ty = ~t_y; bm = ~b;   // must not disturb the snapshot
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({nm, "_latency"}, lat, N + 2);
        check({nm, "_contact"}, contact, exp_c);
        check({nm, "_hit"}, hit, exp_h);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_contact", contact, 0);
        check("rst_hit", hit, 0);

        run_scan(100, 100, 10, pack4(106, 500, 500, 500), pack4(108, 400, 400, 400),
                 4'b0000, 4'b0001, 4'b0001, "circle");
        run_scan(100, 100, 10, pack4(110, 500, 500, 500), pack4(100, 400, 400, 400),
                 4'b0000, 4'b0001, 4'b0000, "edge_eq");
        run_scan(100, 100, 10, pack4(110, 500, 500, 500), pack4(110, 400, 400, 400),
                 4'b0000, 4'b0000, 4'b0000, "corner_circle");
        run_scan(100, 100, 10, pack4(110, 500, 500, 500), pack4(110, 400, 400, 400),
                 4'b0001, 4'b0001, 4'b0000, "corner_box");
        run_scan(0, 0, 1023, pack4(1023, 1023, 1023, 1023), pack4(1023, 1023, 1023, 1023),
                 4'b0000, 4'b0000, 4'b0000, "extreme_circle");
        run_scan(0, 0, 1023, pack4(1023, 1023, 1023, 1023), pack4(1023, 1023, 1023, 1023),
                 4'b1111, 4'b1111, 4'b1110, "extreme_box");

        do_reset();
        for (int s = 1; s <= 13; s++) begin
            int t0;
            t0 = (s % 2 == 1) ? 100 : 500;
            run_scan(100, 100, 10, pack4(t0, 500, 500, 500), pack4(t0, 500, 500, 500),
                     4'b0000, {3'b000, (s % 2 == 1)}, {3'b000, (s == 1 || s == 11)},
                     $sformatf("cooldown_s%0d", s));
        end

        // Second start while busy must be ignored (it would otherwise produce contact)
        @(posedge clk); #1;
        tx = pack4(500, 500, 500, 500); ty = pack4(500, 500, 500, 500); bm = '0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        tx = pack4(100, 500, 500, 500); ty = pack4(100, 500, 500, 500);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("double_start_dones", n, 1);
        check("double_start_contact", contact, 0);

        run_scan(100, 100, 10, pack4(100, 500, 500, 500), pack4(100, 500, 500, 500),
                 4'b0000, 4'b0001, 4'b0000, "pre_abort");

        // Reset lands in the third SCAN cycle
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("abort_dones", n, 0);
        check("abort_contact", contact, 0);
        check("abort_busy", busy, 0);

        run_scan(100, 100, 10, pack4(100, 500, 500, 500), pack4(100, 500, 500, 500),
                 4'b0000, 4'b0001, 4'b0001, "after_abort");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hitbox_scan.md
Name: hitbox_scan

Overview:
- Parametrised multi-target collision engine. It replaces single-pair combinational hit tests in the game datapath.
- On each frame-start pulse it snapshots one object (a projectile or fighter) and N_TARGETS targets. It then tests them sequentially through one shared squared-distance unit.
- Each target can use a circular or axis-aligned box test.
- It produces a per-target contact vector, rising-edge hit pulses with a per-target cooldown, and a done strobe for the game-logic FSM.

Parameters:
- COORD_W, 10, width of unsigned X/Y coordinates and coverage.
- N_TARGETS, 4, number of targets tested per scan (1..16).
- COOLDOWN, 8, number of completed scans after a hit pulse during which further hit pulses for that target are suppressed (0 = no cooldown).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle scan request (typically the frame_clk rising edge).
- Obj_X  in  COORD_W  object centre X.
- Obj_Y  in  COORD_W  object centre Y.
- Coverage  in  COORD_W  hit radius (circle) or half-extent (box).
- Target_X  in  N_TARGETS*COORD_W  target centre X; target i occupies bits [i*COORD_W +: COORD_W].
- Target_Y  in  N_TARGETS*COORD_W  target centre Y; same packing as Target_X.
- box_mode  in  N_TARGETS  per-target shape select: 1 = box test, 0 = circle test.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle strobe when the contact results are updated.
- contact  out  N_TARGETS  registered contact result of the last completed scan.
- hit  out  N_TARGETS  one-cycle strobes of new, non-suppressed contacts, asserted together with done.

Behaviour:
- Reset (synchronous, on any cycle, including mid-scan):
  - state returns to IDLE;
  - busy, done, contact and hit clear to 0;
  - all cooldown counters clear to 0;
  - the in-progress scan is discarded and no done is produced.
- FSM states: IDLE, SCAN, FINISH.
  - IDLE: when start=1, register Obj_X, Obj_Y, Coverage, Target_X, Target_Y and box_mode into snapshot registers, set index to 0, go to SCAN. busy rises on the next cycle.
  - SCAN: each cycle evaluates target[index] and writes its result bit into a pending-result vector. index increments. When index = N_TARGETS-1 has been evaluated, go to FINISH.
  - FINISH: copy pending into contact, pulse done and hit for one cycle, update cooldowns, return to IDLE.
- start is ignored while busy. There is no queueing.
- Latency: start in cycle T gives done in cycle T+N_TARGETS+2. busy is high from T+1 to T+N_TARGETS+1 inclusive; done is asserted at T+N_TARGETS+2 with busy low.
- The earliest accepted restart is start in the same cycle as done: the FSM is in IDLE then and accepts it.
- Arithmetic:
  - dx = Target_X - Obj_X and dy = Target_Y - Obj_Y are signed, COORD_W+1 bits.
  - The circle test computes dx*dx + dy*dy at 2*COORD_W+3 bits with no overflow, and compares it using <= against Coverage*Coverage extended to the same width.
  - The box test is |dx| <= Coverage AND |dy| <= Coverage, using COORD_W+1-bit magnitudes.
  - Equality counts as contact in both modes. Coverage=0 gives contact only when the positions coincide exactly.
  - The signed/unsigned mix must be handled explicitly. Maximum separation (all ones versus 0) must not wrap.
- Hit and cooldown, evaluated per target in FINISH:
  - new = pending[i] & ~contact[i] (contact[i] is the previous scan's result).
  - hit[i] = new & (cd[i] == 0). When hit[i]=1, load cd[i] with COOLDOWN.
  - Otherwise, if cd[i] != 0, decrement cd[i] by 1.
  - A suppressed rising edge is not replayed later.
  - Sustained contact produces exactly one hit, at its first scan.
- Inputs changing during SCAN have no effect, because the snapshot is used.

Test Plan:
- Reset then circle test, N=4, COOLDOWN=8. Obj (100,100), Coverage 10, target0 (106,108) circle, other targets at (500,400). Required: done 6 cycles after start, contact=0001, hit=0001.
- Boundary equality. Target0 (110,100) in circle mode gives contact=1. Target0 (110,110) in circle mode gives 0. The same (110,110) in box mode gives 1.
- Extremes. Obj (0,0), target (1023,1023), Coverage 1023, circle mode. Required: contact=0 with no wrap-around false hit. Box mode required: contact=1.
- Cooldown. Toggle target0 between (100,100) and (500,500) on alternate scans, COOLDOWN=8. Required: hit on scan 1 only. The next hit is on the first rising edge after 8 further scans have completed.
- Busy and reset. Pulse start twice 2 cycles apart: the second is ignored and exactly one done appears. Assert Reset in the 3rd SCAN cycle: no done, contact=0, and the next start scans normally.
